alu_muldiv_unit: RTL and testbench

ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

---
 rtl/alu_muldiv_unit_pkg.sv | 43 ++++
 rtl/alu_muldiv_unit_decode.sv | 38 +++
 rtl/alu_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_unit_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: aluOp and funct
// encodings, the internal operation code and the control FSM states.
`timescale 1ns/1ps
package alu_muldiv_unit_pkg;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_SLTU,
    OP_MULTU,
    OP_DIVU,
    OP_MFHI,
    OP_MFLO,
    OP_ILLEGAL
  } op_e;

endpackage

// File: rtl/alu_muldiv_unit_decode.sv
// Combinational decode of aluOp/funct into an internal operation code;
// anything not recognised becomes OP_ILLEGAL with the illegal flag set.
`timescale 1ns/1ps
module alu_op_decode
  import alu_muldiv_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output op_e        op,
  output logic       illegal
);

  always_comb begin
    op = OP_ILLEGAL;
    case (alu_op)
      ALUOP_ADD:     op = OP_ADD;
      ALUOP_SUB:     op = OP_SUB;
      ALUOP_ILLEGAL: op = OP_ILLEGAL;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:   op = OP_ADD;
          FUNCT_SUB:   op = OP_SUB;
          FUNCT_AND:   op = OP_AND;
          FUNCT_OR:    op = OP_OR;
          FUNCT_SLT:   op = OP_SLT;
          FUNCT_SLTU:  op = OP_SLTU;
          FUNCT_MULTU: op = OP_MULTU;
          FUNCT_DIVU:  op = OP_DIVU;
          FUNCT_MFHI:  op = OP_MFHI;
          FUNCT_MFLO:  op = OP_MFLO;
          default:     op = OP_ILLEGAL;
        endcase
      end
    endcase
    illegal = (op == OP_ILLEGAL);
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// ALU with iterative unsigned multiply (shift-add) and divide (restoring),
// one bit per cycle, results published to HI/LO only when the op completes.
`timescale 1ns/1ps
module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

  op_e  dec_op;
  logic dec_illegal;

  alu_op_decode u_decode (
    .alu_op  (aluOp),
    .funct   (funct),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // Multiply step: acc_hi holds the partial product, acc_lo the remaining
  // multiplier bits; both shift right together as product bits retire.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  // Divide step: acc_hi is the partial remainder, acc_lo shifts the dividend
  // out of its top and quotient bits into its bottom.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_hi_nx, div_lo_nx;
  logic             div_ge, last_iter;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (dec_op)
            OP_MULTU: begin
              state_d  = ST_MUL;
              busy_d   = 1'b1;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = b;
              opnd_d   = a;
            end
            OP_DIVU: begin
              if (b == '0) begin
                state_d  = ST_FIN;
                done_d   = 1'b1;
                hi_d     = a;
                lo_d     = '1;
                result_d = '1;
              end else begin
                state_d  = ST_DIV;
                busy_d   = 1'b1;
                cnt_d    = '0;
                acc_hi_d = '0;
                acc_lo_d = a;
                opnd_d   = b;
              end
            end
            default: begin
              state_d   = ST_FIN;
              done_d    = 1'b1;
              illegal_d = dec_illegal;
              result_d  = alu_res;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        acc_hi_d = (state_q == ST_MUL) ? mul_hi_nx : div_hi_nx;
        acc_lo_d = (state_q == ST_MUL) ? mul_lo_nx : div_lo_nx;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (last_iter) begin
          state_d  = ST_FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          hi_d     = acc_hi_d;
          lo_d     = acc_lo_d;
          result_d = acc_lo_d;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, mid-operation reset and an 8-bit instance.
`timescale 1ns/1ps
module tb_alu_muldiv_unit;
  import alu_muldiv_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, illegal;

  logic         start8 = 1'b0;
  logic [1:0]   alu_op8 = 2'b00;
  logic [5:0]   funct8 = 6'd0;
  logic [7:0]   a8 = '0, b8 = '0;
  logic [7:0]   result8, hi8, lo8;
  logic         zero8, busy8, done8, illegal8;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluOp(alu_op), .funct(funct),
    .a(a), .b(b), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .aluOp(alu_op8), .funct(funct8),
    .a(a8), .b(b8), .result(result8), .zero(zero8), .hi(hi8), .lo(lo8),
    .busy(busy8), .done(done8), .illegal(illegal8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  // Issue one op on the 32-bit unit; returns outputs sampled in the done cycle.
  // Also pokes start during busy and during FIN, both of which must be ignored.
  task automatic run32(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r_res, output logic r_zero, output logic r_ill,
                       output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                       output int lat, output int busy_cycles);
    logic [W-1:0] hi0, lo0;
    @(negedge clk);
    check("done_low_in_idle", done, 1'b0);
    hi0 = hi;
    lo0 = lo;
    alu_op = op; funct = fn; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; funct = 6'($urandom); alu_op = 2'($urandom);
    lat = -1;
    busy_cycles = 0;
    r_res = '0; r_zero = 1'b0; r_ill = 1'b0; r_hi = '0; r_lo = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (k == 10 && busy) begin
        check("hi_held_while_busy", hi, hi0);
        check("lo_held_while_busy", lo, lo0);
      end
      if (done) begin
        lat = k;
        r_res = result; r_zero = zero; r_ill = illegal; r_hi = hi; r_lo = lo;
        break;
      end
      if (k == 5) begin
        start = 1'b1; alu_op = ALUOP_RTYPE; funct = FUNCT_ADD;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b1; alu_op = ALUOP_RTYPE; funct = FUNCT_ADD; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run8(input logic [1:0] op, input logic [5:0] fn,
                      input logic [7:0] av, input logic [7:0] bv,
                      output logic [7:0] r_res, output logic [7:0] r_hi, output logic [7:0] r_lo,
                      output int lat, output int busy_cycles);
    @(negedge clk);
    alu_op8 = op; funct8 = fn; a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = -1;
    busy_cycles = 0;
    r_res = '0; r_hi = '0; r_lo = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy8) busy_cycles++;
      if (done8) begin
        lat = k; r_res = result8; r_hi = hi8; r_lo = lo8;
        break;
      end
    end
  endtask

  // Reference model in plain arithmetic; mhi/mlo track the architectural HI/LO.
  task automatic model(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv,
                       inout logic [31:0] mhi, inout logic [31:0] mlo,
                       output logic [31:0] res, output logic ill, output int lat);
    logic [63:0] p;
    res = '0; ill = 1'b0; lat = 1;
    if (op == 2'b00) res = av + bv;
    else if (op == 2'b01) res = av - bv;
    else if (op == 2'b11) ill = 1'b1;
    else begin
      case (fn)
        FUNCT_ADD:  res = av + bv;
        FUNCT_SUB:  res = av - bv;
        FUNCT_AND:  res = av & bv;
        FUNCT_OR:   res = av | bv;
        FUNCT_SLT:  res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
        FUNCT_SLTU: res = (av < bv) ? 32'd1 : 32'd0;
        FUNCT_MULTU: begin
          p = {32'd0, av} * {32'd0, bv};
          mhi = p[63:32]; mlo = p[31:0]; res = mlo; lat = 33;
        end
        FUNCT_DIVU: begin
          if (bv == 0) begin
            mhi = av; mlo = 32'hFFFF_FFFF;
          end else begin
            mhi = av % bv; mlo = av / bv; lat = 33;
          end
          res = mlo;
        end
        FUNCT_MFHI: res = mhi;
        FUNCT_MFLO: res = mlo;
        default:    ill = 1'b1;
      endcase
    end
  endtask

  vec_t vt[14];
  logic [5:0] legal_fn[10];

  initial begin
    logic [W-1:0] r_res, r_hi, r_lo, e_res, m_hi, m_lo;
    logic [7:0]   r8_res, r8_hi, r8_lo;
    logic         r_zero, r_ill, e_ill, seen_done;
    logic [1:0]   rop;
    logic [5:0]   rfn;
    logic [W-1:0] ra, rb;
    int           lat, bc, e_lat;

    vt[0]  = '{2'b10, FUNCT_ADD,   32'd7,          32'd5,      32'd12,         1'b0, 32'd0, 32'd0,          1};
    vt[1]  = '{2'b10, FUNCT_SLT,   32'hFFFF_FFFF,  32'd1,      32'd1,          1'b0, 32'd0, 32'd0,          1};
    vt[2]  = '{2'b10, FUNCT_SLTU,  32'hFFFF_FFFF,  32'd1,      32'd0,          1'b0, 32'd0, 32'd0,          1};
    vt[3]  = '{2'b01, 6'd0,        32'd9,          32'd9,      32'd0,          1'b0, 32'd0, 32'd0,          1};
    vt[4]  = '{2'b10, 6'b111111,   32'd3,          32'd4,      32'd0,          1'b1, 32'd0, 32'd0,          1};
    vt[5]  = '{2'b10, FUNCT_MULTU, 32'hFFFF_FFFF,  32'd2,      32'hFFFF_FFFE,  1'b0, 32'd1, 32'hFFFF_FFFE,  33};
    vt[6]  = '{2'b10, FUNCT_MFHI,  32'd0,          32'd0,      32'd1,          1'b0, 32'd1, 32'hFFFF_FFFE,  1};
    vt[7]  = '{2'b10, FUNCT_DIVU,  32'd100,        32'd7,      32'd14,         1'b0, 32'd2, 32'd14,         33};
    vt[8]  = '{2'b10, FUNCT_MFLO,  32'd0,          32'd0,      32'd14,         1'b0, 32'd2, 32'd14,         1};
    vt[9]  = '{2'b10, FUNCT_DIVU,  32'd5,          32'd0,      32'hFFFF_FFFF,  1'b0, 32'd5, 32'hFFFF_FFFF,  1};
    vt[10] = '{2'b10, FUNCT_AND,   32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 1'b0, 32'd5, 32'hFFFF_FFFF, 1};
    vt[11] = '{2'b10, FUNCT_OR,    32'h0000_F0F0,  32'h0000_FF00, 32'h0000_FFF0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1};
    vt[12] = '{2'b00, 6'd0,        32'hFFFF_FFFF,  32'd1,      32'd0,          1'b0, 32'd5, 32'hFFFF_FFFF,  1};
    vt[13] = '{2'b11, FUNCT_ADD,   32'd1,          32'd1,      32'd0,          1'b1, 32'd5, 32'hFFFF_FFFF,  1};

    legal_fn = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT,
                 FUNCT_SLTU, FUNCT_MULTU, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO};

    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", zero, 1'b1);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst8_zero", zero8, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run32(vt[i].op, vt[i].fn, vt[i].a, vt[i].b, r_res, r_zero, r_ill, r_hi, r_lo, lat, bc);
      $display("vec %0d: op=%b fn=%b a=0x%0h b=0x%0h -> res=0x%0h hi=0x%0h lo=0x%0h ill=%0b lat=%0d",
               i, vt[i].op, vt[i].fn, vt[i].a, vt[i].b, r_res, r_hi, r_lo, r_ill, lat);
      check($sformatf("vec%0d_result", i), r_res, vt[i].res);
      check($sformatf("vec%0d_zero", i), r_zero, (vt[i].res == 0));
      check($sformatf("vec%0d_illegal", i), r_ill, vt[i].ill);
      check($sformatf("vec%0d_hi", i), r_hi, vt[i].hi);
      check($sformatf("vec%0d_lo", i), r_lo, vt[i].lo);
      check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bc, vt[i].lat - 1);
    end
    m_hi = vt[13].hi;
    m_lo = vt[13].lo;

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0: rop = 2'b00;
        1: rop = 2'b01;
        2: rop = 2'b11;
        default: rop = 2'b10;
      endcase
      rfn = ($urandom_range(0, 10) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 9)];
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model(rop, rfn, ra, rb, m_hi, m_lo, e_res, e_ill, e_lat);
      run32(rop, rfn, ra, rb, r_res, r_zero, r_ill, r_hi, r_lo, lat, bc);
      $display("rnd %0d: op=%b fn=%b a=0x%0h b=0x%0h -> res=0x%0h hi=0x%0h lo=0x%0h lat=%0d",
               i, rop, rfn, ra, rb, r_res, r_hi, r_lo, lat);
      check($sformatf("rnd%0d_result", i), r_res, e_res);
      check($sformatf("rnd%0d_zero", i), r_zero, (e_res == 0));
      check($sformatf("rnd%0d_illegal", i), r_ill, e_ill);
      check($sformatf("rnd%0d_hi", i), r_hi, m_hi);
      check($sformatf("rnd%0d_lo", i), r_lo, m_lo);
      check($sformatf("rnd%0d_latency", i), lat, e_lat);
    end

    // Load nonzero HI/LO, then reset in the middle of a multiply.
    run32(ALUOP_RTYPE, FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r_res, r_zero, r_ill, r_hi, r_lo, lat, bc);
    check("pre_rst_hi", r_hi, 32'hFFFF_FFFE);
    @(negedge clk);
    alu_op = ALUOP_RTYPE; funct = FUNCT_MULTU; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    $display("mid-op reset: busy=%0b hi=0x%0h lo=0x%0h done=%0b", busy, hi, lo, done);
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", done, 1'b0);
    check("midrst_zero", zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 1'b0);

    run8(ALUOP_RTYPE, FUNCT_MULTU, 8'hFF, 8'h02, r8_res, r8_hi, r8_lo, lat, bc);
    $display("w8 multu: res=0x%0h hi=0x%0h lo=0x%0h lat=%0d busy=%0d", r8_res, r8_hi, r8_lo, lat, bc);
    check("w8_mul_hi", r8_hi, 8'h01);
    check("w8_mul_lo", r8_lo, 8'hFE);
    check("w8_mul_result", r8_res, 8'hFE);
    check("w8_mul_latency", lat, 9);
    check("w8_mul_busy", bc, 8);
    run8(ALUOP_RTYPE, FUNCT_DIVU, 8'd200, 8'd7, r8_res, r8_hi, r8_lo, lat, bc);
    $display("w8 divu: res=0x%0h hi=0x%0h lo=0x%0h lat=%0d busy=%0d", r8_res, r8_hi, r8_lo, lat, bc);
    check("w8_div_lo", r8_lo, 8'd28);
    check("w8_div_hi", r8_hi, 8'd4);
    check("w8_div_latency", lat, 9);
    run8(ALUOP_ADD, 6'd0, 8'hF0, 8'h20, r8_res, r8_hi, r8_lo, lat, bc);
    $display("w8 add: res=0x%0h lat=%0d", r8_res, lat);
    check("w8_add_wrap", r8_res, 8'h10);
    check("w8_add_hi_kept", r8_hi, 8'd4);
    check("w8_add_latency", lat, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
